// File: rtl/quad_encoder_ctr.sv
// Quadrature rotary encoder counter with input synchronisers, per-channel
// debounce, x2/x4 decoding, wrap or saturate arithmetic, clear/load, and
// step/direction/illegal-transition reporting.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   a, b       - raw encoder channels (asynchronous)
//   clear      - synchronous clear of value and error
//   load       - synchronous load of load_value (clamped when saturating)
//   load_value - preload value
//   value      - counter
//   step       - one-cycle pulse when a decoded step changes value
//   dir        - direction of last decoded step (1 = up)
//   error      - sticky illegal-transition flag
module quad_encoder_ctr #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] INCREMENT   = WIDTH'(1),
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      DEBOUNCE    = 4,
  parameter int unsigned      MODE        = 0,
  parameter int unsigned      SATURATE    = 0,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             error
);

  localparam int unsigned CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  // Channel index 1 is A, index 0 is B, so {filt[1], filt[0]} = {fa, fb}.
  logic [1:0]             raw_c;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [CNT_W-1:0]       cnt_d  [2];
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             prev_q;
  logic [WIDTH-1:0]       value_q, value_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic                   error_q, error_d;

  logic                   up_c, down_c, illegal_c;
  logic [WIDTH:0]         sum_ext_c;
  logic [WIDTH-1:0]       inc_val_c, dec_val_c, load_val_c;

  assign raw_c = {a, b};

  // Synchroniser shift and debounce filter for both channels.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw_c[ch]};
      filt_d[ch] = filt_q[ch];
      cnt_d[ch]  = '0;
      if (sync_q[ch][SYNC_STAGES-1] != filt_q[ch]) begin
        if (cnt_q[ch] == CNT_W'(DEBOUNCE - 1)) begin
          filt_d[ch] = sync_q[ch][SYNC_STAGES-1];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Transition decode on {prev, filt}; forward order is 00->10->11->01->00.
  always_comb begin
    up_c      = 1'b0;
    down_c    = 1'b0;
    illegal_c = ((prev_q ^ filt_q) == 2'b11);
    if (MODE != 0) begin
      unique case ({prev_q, filt_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up_c   = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: down_c = 1'b1;
        default: ;
      endcase
    end else begin
      unique case ({prev_q, filt_q})
        4'b00_10, 4'b11_01: up_c   = 1'b1;
        4'b00_01, 4'b11_10: down_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Candidate next values; the extra sum bit catches overflow past MAX_VALUE.
  always_comb begin
    sum_ext_c = {1'b0, value_q} + {1'b0, INCREMENT};
    if (SATURATE != 0) begin
      inc_val_c  = (sum_ext_c > {1'b0, MAX_VALUE}) ? MAX_VALUE : sum_ext_c[WIDTH-1:0];
      dec_val_c  = (value_q < INCREMENT) ? '0 : value_q - INCREMENT;
      load_val_c = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    end else begin
      inc_val_c  = sum_ext_c[WIDTH-1:0];
      dec_val_c  = value_q - INCREMENT;
      load_val_c = load_value;
    end
  end

  // Counter update: clear > load > decoded step.
  always_comb begin
    value_d = value_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    error_d = error_q;
    if (clear) begin
      value_d = '0;
      error_d = 1'b0;
    end else if (load) begin
      value_d = load_val_c;
      if (illegal_c) error_d = 1'b1;
    end else if (illegal_c) begin
      error_d = 1'b1;
    end else if (up_c) begin
      value_d = inc_val_c;
      step_d  = (inc_val_c != value_q);
      dir_d   = 1'b1;
    end else if (down_c) begin
      value_d = dec_val_c;
      step_d  = (dec_val_c != value_q);
      dir_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      filt_q  <= '0;
      prev_q  <= '0;
      value_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= sync_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
      end
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      value_q <= value_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      error_q <= error_d;
    end
  end

  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign error = error_q;

endmodule

// File: tb/tb_quad_encoder_ctr.sv
// Directed bench for quad_encoder_ctr: three instances (x4 wrap, x2 wrap,
// x4 saturating at 200) share the same pin stimulus.
module tb_quad_encoder_ctr;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a, b, clear, load;
  logic [7:0] load_value;

  logic [7:0] v4, v2, vs;
  logic       s4, s2, ss, d4, d2, ds, e4, e2, es;

  always #5 clk = ~clk;

  quad_encoder_ctr #(.WIDTH(8), .MODE(1), .SATURATE(0)) u_x4 (
    .clk(clk), .reset(reset_n), .a(a), .b(b), .clear(clear), .load(load),
    .load_value(load_value), .value(v4), .step(s4), .dir(d4), .error(e4));

  quad_encoder_ctr #(.WIDTH(8), .MODE(0), .SATURATE(0)) u_x2 (
    .clk(clk), .reset(reset_n), .a(a), .b(b), .clear(clear), .load(load),
    .load_value(load_value), .value(v2), .step(s2), .dir(d2), .error(e2));

  quad_encoder_ctr #(.WIDTH(8), .MODE(1), .SATURATE(1), .MAX_VALUE(8'd200)) u_sat (
    .clk(clk), .reset(reset_n), .a(a), .b(b), .clear(clear), .load(load),
    .load_value(load_value), .value(vs), .step(ss), .dir(ds), .error(es));

  // Step pulse counters, sampled on the inactive edge.
  int unsigned sc4 = 0, sc2 = 0, scs = 0;
  always @(negedge clk) begin
    if (s4) sc4++;
    if (s2) sc2++;
    if (ss) scs++;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic na, input logic nb);
    @(posedge clk);
    #1;
    a = na;
    b = nb;
  endtask

  task automatic do_load(input logic [7:0] val);
    @(posedge clk);
    #1;
    load_value = val;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] e4;
    logic [7:0] e2;
    logic       d4;
  } vec_t;

  vec_t tbl [16];

  int unsigned base4, base2, bases;

  initial begin
    // Three forward cycles then four reverse transitions.
    tbl[0]  = '{1'b1, 1'b0, 8'd1,  8'd1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 8'd2,  8'd1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'd3,  8'd2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'd4,  8'd2, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 8'd5,  8'd3, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'd6,  8'd3, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'd7,  8'd4, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'd8,  8'd4, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'd9,  8'd5, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'd10, 8'd5, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'd11, 8'd6, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'd12, 8'd6, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'd11, 8'd5, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'd10, 8'd5, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'd9,  8'd4, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'd8,  8'd4, 1'b0};

    reset_n    = 1'b0;
    a          = 1'b0;
    b          = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = 8'd0;

    // Reset with random pin activity.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
    end
    chk("reset_hold_value", 32'(v4), 32'd0);
    a = 1'b0;
    b = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(12);
    chk("reset_value", 32'(v4), 32'd0);
    chk("reset_step",  32'(s4), 32'd0);
    chk("reset_dir",   32'(d4), 32'd0);
    chk("reset_error", 32'(e4), 32'd0);
    chk("reset_value_x2", 32'(v2), 32'd0);

    // Table: forward x4/x2 counting and reverse.
    for (int i = 0; i < 16; i++) begin
      set_ab(tbl[i].a, tbl[i].b);
      tick(10);
      chk($sformatf("tbl%0d_x4_value", i), 32'(v4), 32'(tbl[i].e4));
      chk($sformatf("tbl%0d_x2_value", i), 32'(v2), 32'(tbl[i].e2));
      chk($sformatf("tbl%0d_x4_dir", i),   32'(d4), 32'(tbl[i].d4));
      chk($sformatf("tbl%0d_sat_value", i), 32'(vs), 32'(tbl[i].e4));
      if (i == 11) begin
        chk("fwd_x4_pulses", 32'(sc4), 32'd12);
        chk("fwd_x2_pulses", 32'(sc2), 32'd6);
      end
    end
    chk("tbl_x4_pulses", 32'(sc4), 32'd16);
    chk("tbl_x2_pulses", 32'(sc2), 32'd8);

    // Three-cycle glitch on a is filtered out.
    base4 = sc4;
    set_ab(1'b1, 1'b0);
    tick(3);
    a = 1'b0;
    tick(12);
    chk("glitch_value", 32'(v4), 32'd8);
    chk("glitch_pulses", 32'(sc4 - base4), 32'd0);

    // Stable edge: value moves on the 7th edge after first sampling.
    set_ab(1'b1, 1'b0);
    tick(6);
    chk("latency_edge6_value", 32'(v4), 32'd8);
    tick(1);
    chk("latency_edge7_value", 32'(v4), 32'd9);
    chk("latency_edge7_step",  32'(s4), 32'd1);
    tick(1);
    chk("latency_step_width",  32'(s4), 32'd0);
    tick(5);
    chk("latency_x2_value", 32'(v2), 32'd5);

    // Wrap versus saturate.
    do_load(8'd255);
    chk("load255_x4",  32'(v4), 32'd255);
    chk("load255_sat", 32'(vs), 32'd200);
    bases = scs;
    set_ab(1'b1, 1'b1);
    tick(10);
    chk("wrap_up_x4",  32'(v4), 32'd0);
    chk("wrap_x2_ignored", 32'(v2), 32'd255);
    chk("sat_at_max_value", 32'(vs), 32'd200);
    chk("sat_at_max_pulses", 32'(scs - bases), 32'd0);
    set_ab(1'b0, 1'b1);
    tick(10);
    chk("wrap_up_x2", 32'(v2), 32'd0);
    chk("after_wrap_x4", 32'(v4), 32'd1);

    do_load(8'd199);
    chk("load199_sat", 32'(vs), 32'd199);
    bases = scs;
    set_ab(1'b0, 1'b0);
    tick(10);
    set_ab(1'b1, 1'b0);
    tick(10);
    chk("sat_clamp_value", 32'(vs), 32'd200);
    chk("sat_clamp_pulses", 32'(scs - bases), 32'd1);
    chk("sat_clamp_x4", 32'(v4), 32'd201);

    do_load(8'd0);
    bases = scs;
    set_ab(1'b0, 1'b0);
    tick(10);
    chk("sat_floor_value", 32'(vs), 32'd0);
    chk("sat_floor_pulses", 32'(scs - bases), 32'd0);
    chk("sat_floor_dir", 32'(ds), 32'd0);
    chk("wrap_down_x4", 32'(v4), 32'd255);

    // Illegal 00 -> 11.
    base4 = sc4;
    set_ab(1'b1, 1'b1);
    tick(10);
    chk("illegal_error_x4", 32'(e4), 32'd1);
    chk("illegal_error_x2", 32'(e2), 32'd1);
    chk("illegal_value_x4", 32'(v4), 32'd255);
    chk("illegal_pulses", 32'(sc4 - base4), 32'd0);
    set_ab(1'b0, 1'b1);
    tick(10);
    chk("post_illegal_x4", 32'(v4), 32'd0);
    chk("post_illegal_x2", 32'(v2), 32'd1);
    chk("error_sticky", 32'(e4), 32'd1);

    // Clear coincident with a decoded step.
    base4 = sc4;
    set_ab(1'b0, 1'b0);
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_value", 32'(v4), 32'd0);
    chk("clear_error", 32'(e4), 32'd0);
    chk("clear_step",  32'(s4), 32'd0);
    chk("clear_sat_value", 32'(vs), 32'd0);
    tick(5);
    chk("clear_pulses", 32'(sc4 - base4), 32'd0);
    chk("clear_value_held", 32'(v4), 32'd0);

    // Load coincident with a decoded step.
    set_ab(1'b1, 1'b0);
    tick(6);
    load_value = 8'd42;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    chk("load_coinc_x4", 32'(v4), 32'd42);
    chk("load_coinc_x2", 32'(v2), 32'd42);
    chk("load_coinc_step", 32'(s4), 32'd0);
    tick(5);
    set_ab(1'b1, 1'b1);
    tick(10);
    chk("after_load_x4", 32'(v4), 32'd43);
    chk("after_load_x2", 32'(v2), 32'd42);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_value", 32'(v4), 32'd0);
    chk("async_reset_dir",   32'(d4), 32'd0);
    chk("async_reset_sat",   32'(vs), 32'd0);
    a = 1'b0;
    b = 1'b0;
    tick(3);
    reset_n = 1'b1;
    base4 = sc4;
    tick(12);
    chk("post_reset_value", 32'(v4), 32'd0);
    chk("post_reset_error", 32'(e4), 32'd0);
    chk("post_reset_pulses", 32'(sc4 - base4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
